// File: rtl/convertidor_bin_bcd_pkg.sv
// Display-path package: FSM state encoding, BCD digit type and limits shared
// between the binary-to-BCD converter and the 7-segment display controller.
package convertidor_bin_bcd_pkg;

  typedef enum logic [1:0] {
    REPOSO       = 2'd0,
    CONVIRTIENDO = 2'd1,
    FIN          = 2'd2
  } estado_t;

  localparam int unsigned VALOR_MAX   = 9999;
  localparam int          NUM_DIGITOS = 4;
  localparam int          ANCHO_BCD   = 4 * NUM_DIGITOS;

  typedef logic [3:0] digito_bcd_t;

endpackage

// File: rtl/convertidor_bin_bcd_ajuste.sv
// Double-dabble digit correction: adds 3 to a BCD nibble holding 5..9 so the
// following left shift carries correctly into the next decimal digit.
module ajuste_bcd_digito
  import convertidor_bin_bcd_pkg::*;
(
  input  digito_bcd_t i_Digito,
  output digito_bcd_t o_Digito
);

  always_comb begin
    o_Digito = i_Digito;
    if (i_Digito >= digito_bcd_t'(5)) begin
      o_Digito = i_Digito + digito_bcd_t'(3);
    end
  end

endmodule

// File: rtl/convertidor_bin_bcd.sv
// Sequential binary-to-BCD converter, one bit per clock (ANCHO_BIN+1 cycles to
// result). Digits only change on completion; starts while busy are dropped.
module convertidor_bin_bcd
  import convertidor_bin_bcd_pkg::*;
#(
  parameter int ANCHO_BIN = 14
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Start,
  input  logic [ANCHO_BIN-1:0] i_Binario,
  output logic [3:0]           o_Datos1,
  output logic [3:0]           o_Datos2,
  output logic [3:0]           o_Datos3,
  output logic [3:0]           o_Datos4,
  output logic                 o_Ocupado,
  output logic                 o_Listo,
  output logic                 o_Desborde
);

  localparam int ANCHO_CNT  = $clog2(ANCHO_BIN + 1);
  localparam int ANCHO_TRAB = ANCHO_BIN + ANCHO_BCD;

  localparam logic [ANCHO_CNT-1:0] CNT_ULTIMO = ANCHO_CNT'(ANCHO_BIN - 1);
  localparam logic [ANCHO_CNT-1:0] CNT_UNO    = ANCHO_CNT'(1);
  localparam logic [ANCHO_BIN-1:0] MAX_BIN    = ANCHO_BIN'(VALOR_MAX);

  estado_t                       estado_q, estado_d;
  logic [ANCHO_TRAB-1:0]         trabajo_q, trabajo_d;
  logic [ANCHO_CNT-1:0]          cnt_q, cnt_d;
  logic                          desb_pend_q, desb_pend_d;
  digito_bcd_t [NUM_DIGITOS-1:0] datos_q, datos_d;
  logic                          desborde_q, desborde_d;
  logic                          listo_q, listo_d;

  logic                          entrada_excede;
  logic [ANCHO_BIN-1:0]          binario_carga;
  logic [ANCHO_BCD-1:0]          bcd_ajustado;
  logic [ANCHO_TRAB-1:0]         trabajo_desplazado;
  logic                          ocupado;

  // Working register layout: BCD digits in the top 16 bits, binary below.
  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_ajuste
    ajuste_bcd_digito u_ajuste (
      .i_Digito (trabajo_q[ANCHO_BIN + 4*g +: 4]),
      .o_Digito (bcd_ajustado[4*g +: 4])
    );
  end

  assign trabajo_desplazado = {bcd_ajustado[ANCHO_BCD-2:0], trabajo_q[ANCHO_BIN-1:0], 1'b0};

  assign entrada_excede = 32'(i_Binario) > VALOR_MAX;
  assign binario_carga  = entrada_excede ? MAX_BIN : i_Binario;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      estado_q <= REPOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      REPOSO:       if (i_Start) estado_d = CONVIRTIENDO;
      CONVIRTIENDO: if (cnt_q == CNT_ULTIMO) estado_d = FIN;
      FIN:          estado_d = REPOSO;
      default:      estado_d = REPOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado_q != REPOSO);
  end

  always_comb begin
    trabajo_d   = trabajo_q;
    cnt_d       = cnt_q;
    desb_pend_d = desb_pend_q;
    datos_d     = datos_q;
    desborde_d  = desborde_q;
    listo_d     = 1'b0;
    unique case (estado_q)
      REPOSO: begin
        if (i_Start) begin
          trabajo_d   = {{ANCHO_BCD{1'b0}}, binario_carga};
          cnt_d       = '0;
          desb_pend_d = entrada_excede;
        end
      end
      CONVIRTIENDO: begin
        trabajo_d = trabajo_desplazado;
        cnt_d     = cnt_q + CNT_UNO;
      end
      FIN: begin
        for (int d = 0; d < NUM_DIGITOS; d++) begin
          datos_d[d] = trabajo_q[ANCHO_BIN + 4*d +: 4];
        end
        desborde_d = desb_pend_q;
        listo_d    = 1'b1;
      end
      default: begin
        trabajo_d = trabajo_q;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      trabajo_q   <= '0;
      cnt_q       <= '0;
      desb_pend_q <= 1'b0;
      datos_q     <= '0;
      desborde_q  <= 1'b0;
      listo_q     <= 1'b0;
    end else begin
      trabajo_q   <= trabajo_d;
      cnt_q       <= cnt_d;
      desb_pend_q <= desb_pend_d;
      datos_q     <= datos_d;
      desborde_q  <= desborde_d;
      listo_q     <= listo_d;
    end
  end

  assign o_Datos1   = datos_q[0];
  assign o_Datos2   = datos_q[1];
  assign o_Datos3   = datos_q[2];
  assign o_Datos4   = datos_q[3];
  assign o_Ocupado  = ocupado;
  assign o_Listo    = listo_q;
  assign o_Desborde = desborde_q;

endmodule
